// File: rtl/md_pkg.sv
// Shared encodings and sizing constants for the execute-stage multiply/divide unit.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Wide enough for any latency up to 15 cycles.
    localparam int MD_CNT_W = 4;

    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: 64-bit product or quotient/remainder pair from latched operands.
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div_by_zero
);

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_ub_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    // Signed division goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    always_comb begin
        w_a_mag   = i_a[31] ? (32'd0 - i_a) : i_a;
        w_b_mag   = i_b[31] ? (32'd0 - i_b) : i_b;
        w_b_safe  = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_ub_safe = (i_b == 32'd0) ? 32'd1 : i_b;
        w_q_mag   = w_a_mag / w_b_safe;
        w_r_mag   = w_a_mag % w_b_safe;
        w_q_s     = (i_a[31] ^ i_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
        w_r_s     = i_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
        w_prod_s  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        w_prod_u  = {32'd0, i_a} * {32'd0, i_b};
    end

    always_comb begin
        o_result      = 64'd0;
        o_div_by_zero = 1'b0;
        case (i_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV: begin
                o_result      = {w_r_s, w_q_s};
                o_div_by_zero = (i_b == 32'd0);
            end
            MD_DIVU: begin
                o_result      = {i_a % w_ub_safe, i_a / w_ub_safe};
                o_div_by_zero = (i_b == 32'd0);
            end
            default: o_result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: busy counter, operand latches and architectural HI/LO.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        kill,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mf_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    logic                r_busy;
    logic [MD_CNT_W-1:0] r_cnt;
    logic [2:0]          r_op;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic        w_accept;
    logic [63:0] w_result;
    logic        w_div_by_zero;

    assign w_accept = start & ~r_busy & ~kill & (op != MD_NONE);

    md_calc u_calc (
        .i_op          (r_op),
        .i_a           (r_a),
        .i_b           (r_b),
        .o_result      (w_result),
        .o_div_by_zero (w_div_by_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= MD_NONE;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (r_busy) begin
            // In-flight ops ignore kill and new starts; they always run to completion.
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == MD_CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (!w_div_by_zero) begin
                    r_hi <= w_result[63:32];
                    r_lo <= w_result[31:0];
                end
            end
        end else if (w_accept) begin
            if (md_is_long(op)) begin
                r_op   <= op;
                r_a    <= A;
                r_b    <= B;
                r_busy <= 1'b1;
                r_cnt  <= ((op == MD_DIV) || (op == MD_DIVU)) ? MD_CNT_W'(DIV_CYCLES)
                                                              : MD_CNT_W'(MULT_CYCLES);
            end else if (op == MD_MTHI) begin
                r_hi <= A;
            end else if (op == MD_MTLO) begin
                r_lo <= A;
            end
        end
    end

    assign busy   = r_busy;
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign md_out = mf_sel ? r_lo : r_hi;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, results, kill, reset and back-to-back issue.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        kill;
    logic [31:0] A;
    logic [31:0] B;
    logic        mf_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .kill   (kill),
        .A      (A),
        .B      (B),
        .mf_sel (mf_sel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic k);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        kill  = k;
        step();
        start = 1'b0;
        op    = MD_NONE;
        kill  = 1'b0;
    endtask

    // Counts edges until busy drops, bounded so a stuck unit cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset_hilo: got HI=%h LO=%h expected 0/0", HI, LO);
        end
        checks++;
        if (md_out !== 32'd0) begin errors++; $display("FAIL reset_mdout: got %h expected 0", md_out); end
        $display("reset: busy=%b HI=%h LO=%h", busy, HI, LO);
    endtask

    task automatic run_long(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(o, a, b, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_set: got %b expected 1", name, busy); end
        wait_idle(n);
        checks++;
        if (n != exp_cycles) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_cycles); end
        checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL %s_result: got HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, exp_hi, exp_lo);
        end
        $display("%s: A=%h B=%h cycles=%0d HI=%h LO=%h", name, a, b, n, HI, LO);
    endtask

    task automatic test_mult();
        run_long("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_long("multu", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    endtask

    task automatic test_div();
        run_long("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_long("div_negb", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_long("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_long("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    endtask

    task automatic test_div_by_zero();
        start = 1'b1; op = MD_MTHI; A = 32'h1234; B = 32'd0; kill = 1'b0;
        step();
        checks++;
        if (HI !== 32'h1234 || busy !== 1'b0) begin
            errors++; $display("FAIL mthi: got HI=%h busy=%b expected 00001234/0", HI, busy);
        end
        op = MD_MTLO; A = 32'h5678;
        step();
        start = 1'b0; op = MD_NONE;
        checks++;
        if (LO !== 32'h5678 || HI !== 32'h1234) begin
            errors++; $display("FAIL mtlo: got HI=%h LO=%h expected 00001234/00005678", HI, LO);
        end
        $display("mthi/mtlo: HI=%h LO=%h", HI, LO);
        mf_sel = 1'b0;
        #1;
        checks++;
        if (md_out !== 32'h1234) begin errors++; $display("FAIL mdout_hi: got %h expected 00001234", md_out); end
        mf_sel = 1'b1;
        #1;
        checks++;
        if (md_out !== 32'h5678) begin errors++; $display("FAIL mdout_lo: got %h expected 00005678", md_out); end
        run_long("divu_zero", MD_DIVU, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);
    endtask

    task automatic test_kill();
        int n;
        issue(MD_MULT, 32'd9, 32'd9, 1'b1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL kill_start_busy: got %b expected 0", busy); end
        step();
        checks++;
        if (busy !== 1'b0 || HI !== 32'h1234 || LO !== 32'h5678) begin
            errors++; $display("FAIL kill_start_hilo: got busy=%b HI=%h LO=%h expected 0/00001234/00005678", busy, HI, LO);
        end
        $display("kill_at_start: busy=%b HI=%h LO=%h", busy, HI, LO);
        issue(MD_MULT, 32'd3, 32'd4, 1'b0);
        step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        wait_idle(n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL kill_mid_latency: got %0d expected 3", n); end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd12) begin
            errors++; $display("FAIL kill_mid_result: got HI=%h LO=%h expected 0/0000000c", HI, LO);
        end
        $display("kill_mid: cycles_after_kill=%0d HI=%h LO=%h", n, HI, LO);
    endtask

    task automatic test_reset_mid_op();
        int n;
        issue(MD_DIV, 32'd100, 32'd7, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset_mid: got busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
        end
        step();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset_mid_discard: got busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
        end
        $display("reset_mid_div: busy=%b HI=%h LO=%h", busy, HI, LO);
        issue(MD_MULT, 32'd5, 32'd6, 1'b0);
        step();
        issue(MD_MULTU, 32'd100, 32'd100, 1'b0);
        wait_idle(n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL ignore_start_latency: got %0d expected 3", n); end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd30) begin
            errors++; $display("FAIL ignore_start_result: got HI=%h LO=%h expected 0/0000001e", HI, LO);
        end
        $display("start_while_busy: HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_back_to_back();
        int n;
        issue(MD_MULTU, 32'd7, 32'd8, 1'b0);
        wait_idle(n);
        issue(MD_MULT, 32'hFFFFFFFF, 32'd10, 1'b0);
        checks++;
        if (busy !== 1'b1 || LO !== 32'd56) begin
            errors++; $display("FAIL b2b_accept: got busy=%b LO=%h expected 1/00000038", busy, LO);
        end
        wait_idle(n);
        checks++;
        if (n != 5 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF6) begin
            errors++; $display("FAIL b2b_result: got n=%0d HI=%h LO=%h expected 5/ffffffff/fffffff6", n, HI, LO);
        end
        issue(MD_MTHI, 32'hCAFE0000, 32'd0, 1'b0);
        checks++;
        if (HI !== 32'hCAFE0000 || LO !== 32'hFFFFFFF6) begin
            errors++; $display("FAIL b2b_mthi: got HI=%h LO=%h expected cafe0000/fffffff6", HI, LO);
        end
        $display("back_to_back: HI=%h LO=%h", HI, LO);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = MD_NONE; kill = 1'b0;
        A = 32'd0; B = 32'd0; mf_sel = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_kill();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline with precise exceptions. It sits beside the ALU in E, upstream of the E/M pipeline register. It accepts mult/multu/div/divu/mthi/mtlo requests, models multi-cycle latency with a busy counter, owns the HI/LO registers, and supplies mfhi/mflo read data to the E-stage result mux.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- start  in  1  an MD instruction is in E this cycle.
- op  in  3  operation code (md_pkg): MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
- kill  in  1  exception/interrupt taken this cycle; the E instruction must not take effect.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- mf_sel  in  1  read select: 0 = HI, 1 = LO.
- busy  out  1  multi-cycle operation in progress.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- md_out  out  32  combinational: mf_sel ? LO : HI.

## Operation
Accept condition: `start & ~busy & ~kill & op != MD_NONE`. When the accept condition is false, the request is ignored and no state changes.

Accepted mult/multu/div/divu:
- At the accept edge, the unit latches A, B and op.
- cnt loads MULT_CYCLES or DIV_CYCLES.
- busy goes to 1.

While busy:
- cnt decrements each edge.
- At the edge where cnt goes from 1 to 0, HI/LO are written and busy goes to 0 on the same edge.

Results are computed from the latched operands:
- mult: {HI,LO} = $signed(A) * $signed(B), 64-bit full product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- divu: unsigned quotient and remainder.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero, B == 0: full DIV_CYCLES busy, then HI and LO are left unchanged.

mthi/mtlo:
- When accepted, HI (or LO) = A at the accept edge.
- busy stays 0.

Other rules:
- kill asserted while busy does not abort the in-flight operation; it completes normally.
- A start while busy is ignored. The external stall logic uses `busy | (start & op in mult/div set)` to hold D-stage MD instructions, so this case does not arise in legal operation.
- Reset mid-operation: the pending result is discarded, busy = 0, cnt = 0, HI = LO = 0.

## Timing
- Reset values: busy = 0, HI = 0, LO = 0, cnt = 0, latched operands = 0. md_out then reflects HI/LO (0).
- Mult latency: accept edge T0; busy high for cycles T0+1 … T0+5; HI/LO are new and busy = 0 after edge T0+5.
- Div latency: same pattern with 10 cycles; result visible after edge T0+10.
- mthi/mtlo: new value is visible on HI/LO (and md_out) in the cycle after the accept edge.
- md_out is purely combinational, with no extra cycle.
- A new operation may be accepted in the first cycle that busy reads 0, i.e. back-to-back with no gap cycle.

## Structure
- md_pkg holds:
  - op encodings MD_NONE … MD_MTLO
  - MULT_CYCLES and DIV_CYCLES defaults
  - the counter width constant: 4 bits, sized for DIV_CYCLES ≤ 15
- Sub-module md_calc, purely combinational: takes the latched op, A and B; returns a 64-bit {hi,lo} result and a div_by_zero flag.
- The md_unit top level contains the counter, busy flag, operand latches and HI/LO registers.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (-2), B=3. Required: busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF. Required: after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div with A=-7 (0xFFFFFFF9), B=2. Required: busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Divide-by-zero case, in sequence:
  - Set up with mthi A=0x1234 and mtlo A=0x5678 on consecutive cycles; HI/LO update one cycle after each request.
  - Then divu with B=0. Required: busy for 10 cycles; HI=0x1234 and LO=0x5678 unchanged.
- mult start with kill=1 in the same cycle. Required: busy stays 0 and HI/LO are unchanged. Separately, kill pulsed mid-operation: the result is still written at cycle 5.
- Reset asserted at cycle 3 of a div, then a start issued while busy=1 on a fresh mult. Required: after reset, busy=0 and HI=LO=0. The second start is ignored and does not change the latched operands or the result.
